// File: rtl/iq_integrate_dump_if.sv
// I/Q integrate-and-dump data bus.
// Carries the 4-lane mixer products with per-lane valids toward the stage,
// and the decimated I/Q samples, strobe and overflow flag back out.
//   valid_i            : per-lane valid, bit n qualifies lane n
//   inphase0..3        : signed I products
//   quadrature0..3     : signed Q products
//   i_o / q_o          : signed decimated samples
//   valid_o            : one-cycle output strobe
//   overflow_o         : sticky saturation flag
interface iq_integrate_dump_if #(
   parameter int unsigned IN_W  = 28,
   parameter int unsigned OUT_W = 16
);
   logic        [3:0]       valid_i;
   logic signed [IN_W-1:0]  inphase0;
   logic signed [IN_W-1:0]  inphase1;
   logic signed [IN_W-1:0]  inphase2;
   logic signed [IN_W-1:0]  inphase3;
   logic signed [IN_W-1:0]  quadrature0;
   logic signed [IN_W-1:0]  quadrature1;
   logic signed [IN_W-1:0]  quadrature2;
   logic signed [IN_W-1:0]  quadrature3;
   logic signed [OUT_W-1:0] i_o;
   logic signed [OUT_W-1:0] q_o;
   logic                    valid_o;
   logic                    overflow_o;

   // Upstream mixer side
   modport master (
      output valid_i,
      output inphase0, inphase1, inphase2, inphase3,
      output quadrature0, quadrature1, quadrature2, quadrature3,
      input  i_o, q_o, valid_o, overflow_o
   );

   // Integrate-and-dump stage side
   modport slave (
      input  valid_i,
      input  inphase0, inphase1, inphase2, inphase3,
      input  quadrature0, quadrature1, quadrature2, quadrature3,
      output i_o, q_o, valid_o, overflow_o
   );
endinterface

// File: rtl/iq_integrate_dump.sv
// Decimating integrate-and-dump stage behind the 4-lane I/Q mixer.
// Sums valid lanes per beat, accumulates dec_cfg beats, then emits one
// rounded, right-shifted I/Q pair with a one-cycle valid_o strobe.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   dec_i    : beats per output (0 treated as 1), latched at reset/dump
//   shift_i  : rounding right shift at dump, latched at reset/dump
//   bus      : iq_integrate_dump_if slave (lanes in, samples out)
// Optional: define IQ_INTEGRATE_DUMP_SAT_EN to clamp outputs and drive a
// sticky overflow_o; otherwise outputs wrap and overflow_o is 0.
module iq_integrate_dump #(
   parameter int unsigned IN_W  = 28,
   parameter int unsigned ACC_W = 38,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned DEC_W = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DEC_W-1:0] dec_i,
   input  logic [4:0]       shift_i,
   iq_integrate_dump_if.slave bus
);

   localparam int unsigned LS_W = IN_W + 2;
   localparam int unsigned RW   = ACC_W + 1;

   // Lane vectors
   logic signed [IN_W-1:0] in_i [4];
   logic signed [IN_W-1:0] in_q [4];

   always_comb begin
      in_i[0] = bus.inphase0;
      in_i[1] = bus.inphase1;
      in_i[2] = bus.inphase2;
      in_i[3] = bus.inphase3;
      in_q[0] = bus.quadrature0;
      in_q[1] = bus.quadrature1;
      in_q[2] = bus.quadrature2;
      in_q[3] = bus.quadrature3;
   end

   // Stage A: lane sums
   logic                   beat_c;
   logic signed [LS_W-1:0] sum_i_d, sum_q_d;
   logic signed [LS_W-1:0] sum_i_q, sum_q_q;
   logic                   beat_q;

   always_comb begin
      sum_i_d = '0;
      sum_q_d = '0;
      for (int n = 0; n < 4; n++) begin
         if (bus.valid_i[n]) begin
            sum_i_d = sum_i_d + LS_W'(in_i[n]);
            sum_q_d = sum_q_d + LS_W'(in_q[n]);
         end
      end
   end

   assign beat_c = |bus.valid_i;

   // Stage B: accumulate and detect the dump beat
   logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
   logic signed [ACC_W-1:0] tot_i_c, tot_q_c;
   logic        [DEC_W-1:0] cnt_q;
   logic        [DEC_W-1:0] dec_cfg_q;
   logic        [DEC_W-1:0] dec_norm_c;
   logic        [4:0]       shift_cfg_q;
   logic                    last_c;
   logic                    dump_q;
   logic signed [ACC_W-1:0] tot_i_q, tot_q_q;
   logic        [4:0]       tot_sh_q;

   assign dec_norm_c = (dec_i == '0) ? DEC_W'(1) : dec_i;
   assign tot_i_c    = acc_i_q + ACC_W'(sum_i_q);
   assign tot_q_c    = acc_q_q + ACC_W'(sum_q_q);
   assign last_c     = beat_q && (cnt_q == (dec_cfg_q - DEC_W'(1)));

   // Stage C: round, shift, reduce to OUT_W
   logic signed [RW-1:0]    rnd_add_c;
   logic signed [RW-1:0]    rnd_i_c, rnd_q_c;
   logic signed [RW-1:0]    shf_i_c, shf_q_c;
   logic signed [OUT_W-1:0] out_i_c, out_q_c;
   logic signed [OUT_W-1:0] i_q, q_q;
   logic                    valid_q;

   always_comb begin
      rnd_add_c = (tot_sh_q != 5'd0) ? (RW'(1) << (tot_sh_q - 5'd1)) : '0;
      rnd_i_c   = RW'(tot_i_q) + rnd_add_c;
      rnd_q_c   = RW'(tot_q_q) + rnd_add_c;
      shf_i_c   = rnd_i_c >>> tot_sh_q;
      shf_q_c   = rnd_q_c >>> tot_sh_q;
   end

`ifdef IQ_INTEGRATE_DUMP_SAT_EN
   localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic clamp_i_c, clamp_q_c;
   logic ovf_q;

   // Clamp to the signed OUT_W range
   always_comb begin
      clamp_i_c = 1'b0;
      clamp_q_c = 1'b0;
      out_i_c   = shf_i_c[OUT_W-1:0];
      out_q_c   = shf_q_c[OUT_W-1:0];
      if (shf_i_c > SAT_MAX) begin
         out_i_c   = SAT_MAX[OUT_W-1:0];
         clamp_i_c = 1'b1;
      end else if (shf_i_c < SAT_MIN) begin
         out_i_c   = SAT_MIN[OUT_W-1:0];
         clamp_i_c = 1'b1;
      end
      if (shf_q_c > SAT_MAX) begin
         out_q_c   = SAT_MAX[OUT_W-1:0];
         clamp_q_c = 1'b1;
      end else if (shf_q_c < SAT_MIN) begin
         out_q_c   = SAT_MIN[OUT_W-1:0];
         clamp_q_c = 1'b1;
      end
   end

   // Sticky until reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else if (dump_q && (clamp_i_c || clamp_q_c)) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.overflow_o = ovf_q;
`else
   // Two's-complement wrap: upper bits are intentionally dropped
   logic unused_hi_c;

   assign out_i_c        = shf_i_c[OUT_W-1:0];
   assign out_q_c        = shf_q_c[OUT_W-1:0];
   assign unused_hi_c    = ^{shf_i_c[RW-1:OUT_W], shf_q_c[RW-1:OUT_W]};
   assign bus.overflow_o = 1'b0;
`endif

   // Pipeline registers for stages A, B and C
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_q      <= 1'b0;
         sum_i_q     <= '0;
         sum_q_q     <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         dec_cfg_q   <= dec_norm_c;
         shift_cfg_q <= shift_i;
         dump_q      <= 1'b0;
         tot_i_q     <= '0;
         tot_q_q     <= '0;
         tot_sh_q    <= '0;
         valid_q     <= 1'b0;
         i_q         <= '0;
         q_q         <= '0;
      end else begin
         beat_q <= beat_c;
         if (beat_c) begin
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
         end

         dump_q <= last_c;
         if (beat_q) begin
            if (last_c) begin
               // Dump includes the current beat; new config starts next frame
               acc_i_q     <= '0;
               acc_q_q     <= '0;
               cnt_q       <= '0;
               dec_cfg_q   <= dec_norm_c;
               shift_cfg_q <= shift_i;
               tot_i_q     <= tot_i_c;
               tot_q_q     <= tot_q_c;
               tot_sh_q    <= shift_cfg_q;
            end else begin
               acc_i_q <= tot_i_c;
               acc_q_q <= tot_q_c;
               cnt_q   <= cnt_q + DEC_W'(1);
            end
         end

         valid_q <= dump_q;
         if (dump_q) begin
            i_q <= out_i_c;
            q_q <= out_q_c;
         end
      end
   end

   assign bus.i_o     = i_q;
   assign bus.q_o     = q_q;
   assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Directed self-checking bench for iq_integrate_dump.
module tb_iq_integrate_dump;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [8:0] dec_i;
   logic [4:0] shift_i;

   int total = 0;
   int bad   = 0;
   int strobes;

   iq_integrate_dump_if #(.IN_W(28), .OUT_W(16)) bus ();

   iq_integrate_dump dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .dec_i   (dec_i),
      .shift_i (shift_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock, then settle past the edge before looking at outputs
   task automatic tick();
      @(posedge clk_i);
      #1;
      if (bus.valid_o) strobes++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic lanes(input logic [3:0] v,
                        input int i0, input int i1, input int i2, input int i3,
                        input int q0, input int q1, input int q2, input int q3);
      bus.valid_i     = v;
      bus.inphase0    = 28'(i0);
      bus.inphase1    = 28'(i1);
      bus.inphase2    = 28'(i2);
      bus.inphase3    = 28'(i3);
      bus.quadrature0 = 28'(q0);
      bus.quadrature1 = 28'(q1);
      bus.quadrature2 = 28'(q2);
      bus.quadrature3 = 28'(q3);
   endtask

   task automatic do_reset(input int dec, input int sh);
      dec_i   = 9'(dec);
      shift_i = 5'(sh);
      rst_i   = 1'b1;
      bus.valid_i = 4'h0;
      ticks(2);
      rst_i   = 1'b0;
      strobes = 0;
   endtask

   initial begin
      strobes = 0;
      lanes(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      do_reset(1, 0);
      check("rst_i_o", int'(bus.i_o), 0);
      check("rst_q_o", int'(bus.q_o), 0);
      check("rst_valid", int'(bus.valid_o), 0);
      check("rst_ovf", int'(bus.overflow_o), 0);

      // 1: dec=1, two back-to-back beats, 2-cycle latency
      lanes(4'hF, 1, 2, 3, 4, -1, -1, -1, -1);
      tick();
      check("t1_lat_e0", int'(bus.valid_o), 0);
      tick();
      check("t1_lat_e1", int'(bus.valid_o), 0);
      bus.valid_i = 4'h0;
      tick();
      check("t1_valid0", int'(bus.valid_o), 1);
      check("t1_i0", int'(bus.i_o), 10);
      check("t1_q0", int'(bus.q_o), -4);
      tick();
      check("t1_valid1", int'(bus.valid_o), 1);
      check("t1_i1", int'(bus.i_o), 10);
      tick();
      check("t1_valid_end", int'(bus.valid_o), 0);
      check("t1_hold", int'(bus.i_o), 10);

      // 2: dec=4, shift=2
      do_reset(4, 2);
      lanes(4'hF, 100, 100, 100, 100, -100, -100, -100, -100);
      ticks(4);
      bus.valid_i = 4'h0;
      tick();
      check("t2_no_early", strobes, 0);
      tick();
      check("t2_valid", int'(bus.valid_o), 1);
      check("t2_i", int'(bus.i_o), 400);
      check("t2_q", int'(bus.q_o), -400);
      strobes = 0;
      bus.valid_i = 4'hF;
      ticks(3);
      bus.valid_i = 4'h0;
      ticks(4);
      check("t2_no_strobe_3beats", strobes, 0);
      check("t2_hold_i", int'(bus.i_o), 400);
      bus.valid_i = 4'hF;
      tick();
      bus.valid_i = 4'h0;
      ticks(2);
      check("t2_second", int'(bus.valid_o), 1);
      check("t2_second_i", int'(bus.i_o), 400);

      // 3: sparse lanes and idle cycles
      do_reset(2, 0);
      lanes(4'b0101, 10, 1000, 20, 7, 0, 0, 0, 0);
      tick();
      bus.valid_i = 4'h0;
      ticks(3);
      check("t3_no_early", strobes, 0);
      bus.valid_i = 4'b0101;
      tick();
      bus.valid_i = 4'h0;
      ticks(2);
      check("t3_valid", int'(bus.valid_o), 1);
      check("t3_i", int'(bus.i_o), 60);
      check("t3_q", int'(bus.q_o), 0);

      // 4: rounding with shift=2
      do_reset(1, 2);
      lanes(4'b0001, 6, 0, 0, 0, 0, 0, 0, 0);
      tick();
      bus.inphase0 = -28'sd6;
      tick();
      bus.inphase0 = 28'sd5;
      tick();
      check("t4_i_pos", int'(bus.i_o), 2);
      bus.valid_i = 4'h0;
      tick();
      check("t4_i_neg", int'(bus.i_o), -1);
      tick();
      check("t4_i_five", int'(bus.i_o), 1);
      check("t4_valid", int'(bus.valid_o), 1);

      // 5: output range overflow
      do_reset(1, 0);
      lanes(4'b0001, 40000, 0, 0, 0, 0, 0, 0, 0);
      tick();
      bus.valid_i = 4'h0;
      ticks(2);
`ifdef IQ_INTEGRATE_DUMP_SAT_EN
      check("t5_i_sat", int'(bus.i_o), 32767);
      check("t5_ovf", int'(bus.overflow_o), 1);
`else
      check("t5_i_wrap", int'(bus.i_o), -25536);
      check("t5_ovf", int'(bus.overflow_o), 0);
`endif
      lanes(4'b0001, 5, 0, 0, 0, 0, 0, 0, 0);
      tick();
      bus.valid_i = 4'h0;
      ticks(4);
      check("t5_i_small", int'(bus.i_o), 5);
`ifdef IQ_INTEGRATE_DUMP_SAT_EN
      check("t5_ovf_held", int'(bus.overflow_o), 1);
`else
      check("t5_ovf_held", int'(bus.overflow_o), 0);
`endif
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("t5_ovf_rst", int'(bus.overflow_o), 0);

      // 6: reset aborts a frame; mid-frame dec change waits a frame
      do_reset(4, 0);
      lanes(4'hF, 1, 1, 1, 1, 0, 0, 0, 0);
      ticks(2);
      rst_i = 1'b1;
      tick();
      check("t6_rst_valid", int'(bus.valid_o), 0);
      rst_i = 1'b0;
      strobes = 0;
      ticks(4);
      bus.valid_i = 4'h0;
      tick();
      check("t6_no_abort_strobe", strobes, 0);
      tick();
      check("t6_valid", int'(bus.valid_o), 1);
      check("t6_i", int'(bus.i_o), 16);
      tick();
      strobes = 0;
      bus.valid_i = 4'hF;
      tick();
      dec_i = 9'd2;
      ticks(3);
      bus.valid_i = 4'h0;
      tick();
      check("t6_old_dec_held", strobes, 0);
      tick();
      check("t6_old_dec_valid", int'(bus.valid_o), 1);
      check("t6_old_dec_i", int'(bus.i_o), 16);
      tick();
      bus.valid_i = 4'hF;
      ticks(2);
      bus.valid_i = 4'h0;
      ticks(2);
      check("t6_new_dec_valid", int'(bus.valid_o), 1);
      check("t6_new_dec_i", int'(bus.i_o), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
